// File: rtl/uart_pkg.sv
// Shared definitions for the multi-channel UART receive arbiter.
package uart_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_e;

  function automatic int chanIdxWidth(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/uart_chan_fifo.sv
// Per-channel byte FIFO with fall-through read: when empty, data_o shows the
// incoming byte so a same-cycle push and pop passes the byte straight through.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_chan_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          wrEn;
  logic          rdEn;

  assign full_o  = (count_q == DEPTH_W);
  assign empty_o = (count_q == '0);
  assign wrEn    = push_i & (~full_o | pop_i);
  assign rdEn    = pop_i & (~empty_o | push_i);
  assign data_o  = empty_o ? data_i : mem_q[rdPtr_q];

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrEn) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (rdEn) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({wrEn, rdEn})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_arbiter.sv
// Merges NCH UART receive byte streams into one ready/valid output using
// round-robin selection over per-channel FIFOs, with sticky overrun flags.
module uart_rx_arbiter
  import uart_pkg::*;
#(
  parameter int  NCH   = 4,
  parameter int  DW    = 8,
  parameter int  DEPTH = 2,
  localparam int CW    = chanIdxWidth(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_avl,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    chan_en,
  input  logic              out_rdy,
  output logic              out_avl,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_chan,
  input  logic [NCH-1:0]    ovr_clr,
  output logic [NCH-1:0]    ovr
);

  localparam logic [CW:0] NCH_W = (CW + 1)'(NCH);

  arb_state_e     state_q;
  logic [DW-1:0]  outData_q;
  logic [CW-1:0]  outChan_q;
  logic [CW-1:0]  lastGrant_q;
  logic [NCH-1:0] ovr_q;
  logic [NCH-1:0] ovr_d;

  logic [NCH-1:0] pushReq;
  logic [NCH-1:0] fifoFull;
  logic [NCH-1:0] fifoEmpty;
  logic [NCH-1:0] fifoPop;
  logic [NCH-1:0] chanReq;
  logic [NCH-1:0] overrun;
  logic [DW-1:0]  fifoData [NCH];
  logic           anyReq;
  logic           loadNext;
  logic [CW-1:0]  winIdx;

  assign pushReq = in_avl & chan_en;
  assign chanReq = ~fifoEmpty | pushReq;
  assign overrun = pushReq & fifoFull & ~fifoPop;
  assign ovr_d   = (ovr_q & ~ovr_clr) | overrun;

  for (genvar gi = 0; gi < NCH; gi++) begin : gChan
    uart_chan_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) uFifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (pushReq[gi]),
      .pop_i   (fifoPop[gi]),
      .data_i  (in_data[gi*DW +: DW]),
      .data_o  (fifoData[gi]),
      .full_o  (fifoFull[gi]),
      .empty_o (fifoEmpty[gi])
    );
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    logic [CW:0] cand;
    cand   = '0;
    winIdx = '0;
    anyReq = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      cand = {1'b0, lastGrant_q} + (CW + 1)'(k);
      if (cand >= NCH_W) begin
        cand = cand - NCH_W;
      end
      if (!anyReq && chanReq[cand[CW-1:0]]) begin
        anyReq = 1'b1;
        winIdx = cand[CW-1:0];
      end
    end
  end

  // A new byte can be loaded when idle or when the current one is accepted.
  always_comb begin
    loadNext = anyReq && ((state_q == IDLE) || out_rdy);
    fifoPop  = '0;
    if (loadNext) begin
      fifoPop[winIdx] = 1'b1;
    end
  end

  // Output FSM with registered byte, channel and grant pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      outData_q   <= '0;
      outChan_q   <= '0;
      lastGrant_q <= CW'(NCH - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (loadNext) begin
            state_q     <= PRESENT;
            outData_q   <= fifoData[winIdx];
            outChan_q   <= winIdx;
            lastGrant_q <= winIdx;
          end
        end
        PRESENT: begin
          if (out_rdy) begin
            if (loadNext) begin
              outData_q   <= fifoData[winIdx];
              outChan_q   <= winIdx;
              lastGrant_q <= winIdx;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky overrun flags; a new overrun beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign out_avl  = (state_q == PRESENT);
  assign out_data = outData_q;
  assign out_chan = outChan_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Bench for uart_rx_arbiter: directed scenarios plus random traffic, all
// compared against a queue-level reference model of the arbiter.
module tb_uart_rx_arbiter;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    in_avl;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    chan_en;
  logic              out_rdy;
  logic              out_avl;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic [NCH-1:0]    ovr_clr;
  logic [NCH-1:0]    ovr;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: buffered bytes per channel, front at index 0.
  logic [DW-1:0]  mBuf [NCH][DEPTH+1];
  int             mCnt [NCH];
  int             mLast;
  bit             mPres;
  logic [DW-1:0]  mData;
  int             mChan;
  logic [NCH-1:0] mOvr;

  always #5 clk = ~clk;

  uart_rx_arbiter #(
    .NCH   (NCH),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_avl   (in_avl),
    .in_data  (in_data),
    .chan_en  (chan_en),
    .out_rdy  (out_rdy),
    .out_avl  (out_avl),
    .out_data (out_data),
    .out_chan (out_chan),
    .ovr_clr  (ovr_clr),
    .ovr      (ovr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mCnt[i] = 0;
    end
    mLast = NCH - 1;
    mPres = 1'b0;
    mData = '0;
    mChan = 0;
    mOvr  = '0;
  endtask

  // One cycle of the behavioural rules, evaluated on the currently driven inputs.
  task automatic modelStep();
    int             win;
    int             c;
    bit             canLoad;
    bit             ovrNow;
    logic [NCH-1:0] inc;
    logic [DW-1:0]  popped;
    win     = -1;
    popped  = '0;
    canLoad = !mPres || out_rdy;
    inc     = in_avl & chan_en;
    if (canLoad) begin
      for (int k = 1; k <= NCH; k++) begin
        c = (mLast + k) % NCH;
        if (win < 0 && (mCnt[c] > 0 || inc[c])) begin
          win = c;
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      ovrNow = 1'b0;
      if (inc[i]) begin
        if (mCnt[i] < DEPTH || win == i) begin
          mBuf[i][mCnt[i]] = in_data[i*DW +: DW];
          mCnt[i]++;
        end else begin
          ovrNow = 1'b1;
        end
      end
      if (win == i) begin
        popped = mBuf[i][0];
        for (int j = 0; j < DEPTH; j++) begin
          mBuf[i][j] = mBuf[i][j+1];
        end
        mCnt[i]--;
      end
      mOvr[i] = (mOvr[i] && !ovr_clr[i]) || ovrNow;
    end
    if (canLoad) begin
      if (win >= 0) begin
        mPres = 1'b1;
        mData = popped;
        mChan = win;
        mLast = win;
      end else begin
        mPres = 1'b0;
      end
    end
  endtask

  task automatic compareModel();
    checkOutput("out_avl", out_avl, mPres);
    if (mPres) begin
      checkOutput("out_data", out_data, mData);
      checkOutput("out_chan", out_chan, mChan);
    end
    checkOutput("ovr", ovr, mOvr);
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] avl, input logic [NCH*DW-1:0] data,
                               input logic [NCH-1:0] en, input logic rdy,
                               input logic [NCH-1:0] clr);
    @(negedge clk);
    in_avl  = avl;
    in_data = data;
    chan_en = en;
    out_rdy = rdy;
    ovr_clr = clr;
    modelStep();
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      applyStimulus('0, '0, '1, rdy, '0);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst     = 1'b1;
    in_avl  = '0;
    in_data = '0;
    chan_en = '1;
    out_rdy = 1'b0;
    ovr_clr = '0;
    modelReset();
    #1;
    checkOutput("rst_out_avl", out_avl, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_chan", out_chan, 0);
    checkOutput("rst_ovr", ovr, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [NCH*DW-1:0] vec;
    logic [NCH-1:0]    en;
    rst     = 1'b1;
    in_avl  = '0;
    in_data = '0;
    chan_en = '1;
    out_rdy = 1'b0;
    ovr_clr = '0;
    modelReset();
    repeat (2) @(posedge clk);
    doReset();

    // Single byte on channel 2 appears the next cycle, then output goes idle.
    applyStimulus(4'b0100, {8'h00, 8'h41, 8'h00, 8'h00}, '1, 1'b1, '0);
    checkOutput("single_avl", out_avl, 1);
    checkOutput("single_data", out_data, 8'h41);
    checkOutput("single_chan", out_chan, 2);
    idleCycles(1, 1'b1);
    checkOutput("single_idle", out_avl, 0);

    // Four simultaneous bytes come out in channel order on consecutive cycles.
    doReset();
    applyStimulus(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, '1, 1'b1, '0);
    for (int k = 0; k < NCH; k++) begin
      checkOutput("simul_chan", out_chan, k);
      checkOutput("simul_data", out_data, 8'h10 + k);
      idleCycles(1, 1'b1);
    end
    checkOutput("simul_idle", out_avl, 0);

    // Backpressure on channel 1 fills the FIFO, then a fourth byte overruns.
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hA0, 8'h00}, '1, 1'b0, '0);
    checkOutput("bp_first", out_data, 8'hA0);
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hA1, 8'h00}, '1, 1'b0, '0);
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hA2, 8'h00}, '1, 1'b0, '0);
    checkOutput("bp_held", out_data, 8'hA0);
    checkOutput("bp_no_ovr", ovr[1], 0);
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hA3, 8'h00}, '1, 1'b0, '0);
    checkOutput("bp_ovr_set", ovr[1], 1);
    checkOutput("bp_still_held", out_data, 8'hA0);
    applyStimulus('0, '0, '1, 1'b0, 4'b0010);
    checkOutput("clr_alone", ovr[1], 0);

    // Full FIFO with a same-cycle pop accepts the new byte without overrun.
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hA4, 8'h00}, '1, 1'b1, '0);
    checkOutput("fullpop_ovr", ovr[1], 0);
    checkOutput("fullpop_data", out_data, 8'hA1);
    idleCycles(1, 1'b1);
    checkOutput("drain_a2", out_data, 8'hA2);
    idleCycles(1, 1'b1);
    checkOutput("drain_a4", out_data, 8'hA4);
    idleCycles(1, 1'b1);
    checkOutput("drain_empty", out_avl, 0);

    // A clear coincident with a new overrun leaves the flag set.
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hB0, 8'h00}, '1, 1'b0, '0);
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hB1, 8'h00}, '1, 1'b0, '0);
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hB2, 8'h00}, '1, 1'b0, '0);
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hB3, 8'h00}, '1, 1'b0, 4'b0010);
    checkOutput("clr_race", ovr[1], 1);
    applyStimulus('0, '0, '1, 1'b0, 4'b0010);
    checkOutput("clr_after_race", ovr[1], 0);

    // Reset while presenting with buffered bytes discards everything.
    applyStimulus(4'b0011, {8'h00, 8'h00, 8'hC1, 8'hC0}, '1, 1'b0, '0);
    checkOutput("pre_rst_avl", out_avl, 1);
    doReset();
    applyStimulus(4'b1000, {8'h5C, 8'h00, 8'h00, 8'h00}, '1, 1'b1, '0);
    checkOutput("post_rst_chan", out_chan, 3);
    checkOutput("post_rst_data", out_data, 8'h5C);
    idleCycles(1, 1'b1);
    checkOutput("post_rst_idle", out_avl, 0);

    // Random traffic, including disabled channels and sporadic clears.
    for (int c = 0; c < 600; c++) begin
      vec = NCH*DW'($urandom);
      en  = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '1;
      applyStimulus(NCH'($urandom & $urandom), vec, en,
                    ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0);
    end
    idleCycles(12, 1'b1);
    checkOutput("final_idle", out_avl, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
